// File: rtl/keystore_pkg.sv
// keystore_pkg: shared state enum, key provisioning defaults and the per-master response record
package keystore_pkg;
  typedef enum logic {CLEAR, SERVE} state_t;
  localparam logic [31:0] KEY_DEFAULT = 32'h1035_9987;
  localparam int KEY_IDX_DEFAULT = 0;
  typedef struct packed {
    logic rvalid;
    logic err;
    logic [31:0] data;
  } rsp_t;
endpackage

// File: rtl/keystore_mem_ctrl_if.sv
// keystore_mem_ctrl_if: one master's request (req/we/address/wd) and response (gnt/rvalid/data_out/err) bundle
interface keystore_mem_ctrl_if;
  logic req;
  logic we;
  logic [31:0] address;
  logic [31:0] wd;
  logic gnt;
  logic rvalid;
  logic [31:0] data_out;
  logic err;
  modport master(output req, we, address, wd, input gnt, rvalid, data_out, err);
  modport slave(input req, we, address, wd, output gnt, rvalid, data_out, err);
endinterface

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin arbiter; req[1:0] in, one-hot combinational gnt[1:0] out, priority flips after each grant
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] gnt
);
  logic r_ptr;
  assign gnt = (req == 2'b11) ? (r_ptr ? 2'b10 : 2'b01) : req;
  always_ff @(posedge clk) begin
    if (reset) r_ptr <= 1'b0;
    else if (|gnt) r_ptr <= gnt[0];
  end
endmodule

// File: rtl/keystore_mem_ctrl.sv
// keystore_mem_ctrl: key memory init sequencer plus two-master round-robin access with lock/read protection; ports clk, reset, m0/m1 bus, lock_set/lock_idx, init_done
module keystore_mem_ctrl
  import keystore_pkg::*;
#(
  parameter int          DEPTH   = 32,
  parameter logic [31:0] KEY     = KEY_DEFAULT,
  parameter int          KEY_IDX = KEY_IDX_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  keystore_mem_ctrl_if.slave   m0,
  keystore_mem_ctrl_if.slave   m1,
  input  logic                 lock_set,
  input  logic [4:0]           lock_idx,
  output logic                 init_done
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] KIDX = AW'(KEY_IDX);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  state_t            r_state;
  logic [AW-1:0]     r_cnt;
  logic [DEPTH-1:0]  r_lock;
  logic [31:0]       r_mem [DEPTH];
  rsp_t              r_rsp [2];
  logic              r_init_done;
  logic              w_serve, w_sel, w_we, w_oor, w_locked, w_err, w_lidx_ok, w_mem_we, w_unused;
  logic [1:0]        w_gnt;
  logic [31:0]       w_addr, w_wd, w_data, w_mem_wd;
  logic [29:0]       w_word;
  logic [AW-1:0]     w_idx, w_mem_idx;
  assign w_serve = r_state == SERVE;
  rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req   ({m1.req, m0.req} & {2{w_serve}}),
    .gnt   (w_gnt)
  );
  assign w_sel     = w_gnt[1];
  assign w_addr    = w_sel ? m1.address : m0.address;
  assign w_we      = w_sel ? m1.we : m0.we;
  assign w_wd      = w_sel ? m1.wd : m0.wd;
  assign w_word    = w_addr[31:2];
  assign w_unused  = ^w_addr[1:0];
  assign w_oor     = {2'b0, w_word} >= 32'(DEPTH);
  assign w_idx     = w_word[AW-1:0];
  assign w_lidx_ok = 32'(lock_idx) < 32'(DEPTH);
  // a lock landing in the same cycle as the access already counts against it
  assign w_locked  = r_lock[w_idx] | (lock_set & w_lidx_ok & (lock_idx[AW-1:0] == w_idx));
  // writes to locked words are refused for both masters; locked reads only for m1
  assign w_err     = w_oor | (w_locked & (w_we | w_sel));
  assign w_data    = w_err ? 32'h0 : (w_we ? w_wd : r_mem[w_idx]);
  assign w_mem_we  = !reset & (w_serve ? (|w_gnt & w_we & !w_err) : 1'b1);
  assign w_mem_idx = w_serve ? w_idx : r_cnt;
  assign w_mem_wd  = w_serve ? w_wd : ((r_cnt == KIDX) ? KEY : 32'h0);
  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_mem_idx] <= w_mem_wd;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= CLEAR;
      r_cnt       <= '0;
      r_lock      <= '0;
      r_init_done <= 1'b0;
      r_rsp[0]    <= '0;
      r_rsp[1]    <= '0;
    end else if (!w_serve) begin
      r_cnt <= r_cnt + 1'b1;
      if (r_cnt == KIDX) r_lock[KIDX] <= 1'b1;
      if (r_cnt == LAST) begin
        r_state     <= SERVE;
        r_init_done <= 1'b1;
      end
    end else begin
      if (lock_set & w_lidx_ok) r_lock[lock_idx[AW-1:0]] <= 1'b1;
      for (int i = 0; i < 2; i++) begin
        r_rsp[i].rvalid <= w_gnt[i];
        if (w_gnt[i]) begin
          r_rsp[i].err  <= w_err;
          r_rsp[i].data <= w_data;
        end
      end
    end
  end
  assign m0.gnt      = w_gnt[0];
  assign m1.gnt      = w_gnt[1];
  assign m0.rvalid   = r_rsp[0].rvalid;
  assign m1.rvalid   = r_rsp[1].rvalid;
  assign m0.err      = r_rsp[0].err;
  assign m1.err      = r_rsp[1].err;
  assign m0.data_out = r_rsp[0].data;
  assign m1.data_out = r_rsp[1].data;
  assign init_done   = r_init_done;
endmodule

// File: tb/tb_keystore_mem_ctrl.sv
// tb_keystore_mem_ctrl: directed self-checking bench for keystore_mem_ctrl
module tb_keystore_mem_ctrl;
  localparam logic [31:0] KEY = 32'h1035_9987;
  logic clk, reset, lock_set, init_done;
  logic [4:0] lock_idx;
  int checks, errors;
  keystore_mem_ctrl_if ifm0 ();
  keystore_mem_ctrl_if ifm1 ();
  keystore_mem_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .m0        (ifm0),
    .m1        (ifm1),
    .lock_set  (lock_set),
    .lock_idx  (lock_idx),
    .init_done (init_done)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic drive(input int m, input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    if (m == 0) begin
      ifm0.req = r; ifm0.we = w; ifm0.address = a; ifm0.wd = d;
    end else begin
      ifm1.req = r; ifm1.we = w; ifm1.address = a; ifm1.wd = d;
    end
  endtask
  task automatic go(input int m, input logic w, input logic [31:0] a, input logic [31:0] d,
                    input logic e, input logic [31:0] xd, input string tag);
    drive(m, 1'b1, w, a, d);
    #1;
    chk({tag, ":gnt"}, (m == 0) ? ifm0.gnt : ifm1.gnt, 1);
    chk({tag, ":other_gnt"}, (m == 0) ? ifm1.gnt : ifm0.gnt, 0);
    @(negedge clk);
    drive(m, 1'b0, 1'b0, 32'h0, 32'h0);
    chk({tag, ":rvalid"}, (m == 0) ? ifm0.rvalid : ifm1.rvalid, 1);
    chk({tag, ":other_rvalid"}, (m == 0) ? ifm1.rvalid : ifm0.rvalid, 0);
    chk({tag, ":err"}, (m == 0) ? ifm0.err : ifm1.err, 32'(e));
    chk({tag, ":data"}, (m == 0) ? ifm0.data_out : ifm1.data_out, xd);
  endtask
  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    lock_set = 1'b0;
    lock_idx = 5'd0;
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    chk("reset:init_done", init_done, 0);
    chk("reset:m0_rvalid", ifm0.rvalid, 0);
    chk("reset:m1_rvalid", ifm1.rvalid, 0);
    chk("reset:m0_data", ifm0.data_out, 0);
    reset = 1'b0;
    drive(0, 1, 0, 32'h0, 32'h0);
    #1;
    chk("clear:no_gnt", ifm0.gnt, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0);
    repeat (30) @(negedge clk);
    chk("init:not_yet", init_done, 0);
    @(negedge clk);
    chk("init:done", init_done, 1);
    chk("init:no_rvalid", ifm0.rvalid, 0);
    go(0, 0, 32'h0, 0, 0, KEY, "key_read");
    go(0, 0, 32'h4, 0, 0, 32'h0, "word1_read");
    go(1, 1, 32'h0, 32'hDEAD_BEEF, 1, 32'h0, "key_write_m1");
    go(0, 0, 32'h0, 0, 0, KEY, "key_still");
    go(1, 0, 32'h0, 0, 1, 32'h0, "key_read_m1");
    drive(0, 1, 0, 32'h4, 0);
    drive(1, 1, 0, 32'h4, 0);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("arb%0d:gnt", i), {30'h0, ifm1.gnt, ifm0.gnt}, (i % 2 == 0) ? 32'h1 : 32'h2);
      @(negedge clk);
      chk($sformatf("arb%0d:rvalid", i), {30'h0, ifm1.rvalid, ifm0.rvalid}, (i % 2 == 0) ? 32'h1 : 32'h2);
    end
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    go(1, 0, 32'h4, 0, 0, 32'h0, "lone_m1");
    lock_set = 1'b1;
    lock_idx = 5'd5;
    go(1, 1, 32'h14, 32'h1234, 1, 32'h0, "lock_race");
    lock_set = 1'b0;
    go(0, 0, 32'h14, 0, 0, 32'h0, "locked_m0_read");
    go(1, 0, 32'h14, 0, 1, 32'h0, "locked_m1_read");
    go(0, 1, 32'h80, 32'h5555_5555, 1, 32'h0, "oor_write");
    go(0, 1, 32'h84, 32'h6666_6666, 1, 32'h0, "oor_write33");
    go(0, 0, 32'h4, 0, 0, 32'h0, "word1_unchanged");
    go(0, 0, 32'h0, 0, 0, KEY, "key_unchanged");
    go(1, 0, 32'h80, 0, 1, 32'h0, "oor_read");
    go(0, 1, 32'h7C, 32'hA5A5_A5A5, 0, 32'hA5A5_A5A5, "top_write");
    go(1, 0, 32'h7C, 0, 0, 32'hA5A5_A5A5, "top_read");
    go(0, 1, 32'h8, 32'h1111_2222, 0, 32'h1111_2222, "b2b_write");
    go(0, 0, 32'h8, 0, 0, 32'h1111_2222, "b2b_read");
    @(negedge clk);
    chk("idle:m0_rvalid", ifm0.rvalid, 0);
    chk("idle:data_hold", ifm0.data_out, 32'h1111_2222);
    drive(0, 1, 0, 32'h0, 0);
    #1;
    chk("rst_mid:gnt", ifm0.gnt, 1);
    reset = 1'b1;
    @(negedge clk);
    drive(0, 0, 0, 0, 0);
    chk("rst_mid:no_rvalid", ifm0.rvalid, 0);
    chk("rst_mid:init_done", init_done, 0);
    reset = 1'b0;
    repeat (32) @(negedge clk);
    chk("reinit:done", init_done, 1);
    go(0, 0, 32'h0, 0, 0, KEY, "reinit_key");
    go(0, 0, 32'h7C, 0, 0, 32'h0, "reinit_cleared");
    go(1, 1, 32'h14, 32'h77, 0, 32'h77, "unlock5_write");
    go(1, 0, 32'h14, 0, 0, 32'h77, "unlock5_read");
    go(1, 0, 32'h0, 0, 1, 32'h0, "relock_key_m1");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
